frame_minmax: RTL

FRAME_MINMAX -- requirements
Module: frame_minmax

---
 rtl/frame_minmax.sv | 125 ++++++++++++
 1 files changed

// File: rtl/frame_minmax.sv
// ============================================================================
// frame_minmax : per-frame unsigned min/max of FRAME_LEN samples, held until
//                consumed. Define FRAME_MINMAX_IDX_EN to add min/max positions.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module frame_minmax #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_min,
  output logic [WIDTH-1:0]             out_max
`ifdef FRAME_MINMAX_IDX_EN
  ,
  output logic [$clog2(FRAME_LEN)-1:0] out_min_idx,
  output logic [$clog2(FRAME_LEN)-1:0] out_max_idx
`endif
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic accept_d;
  logic first_d;
  logic take_min_d;
  logic take_max_d;

  assign accept_d   = (state_q == COLLECT) && in_valid;
  assign first_d    = (cnt_q == '0);
  // Strict compares so that ties keep the earliest occurrence.
  assign take_min_d = accept_d && (first_d || (in_data < min_q));
  assign take_max_d = accept_d && (first_d || (in_data > max_q));

`ifdef FRAME_MINMAX_IDX_EN
  logic [CW-1:0] min_idx_q;
  logic [CW-1:0] max_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_idx_q <= '0;
      max_idx_q <= '0;
    end else if (!clr) begin
      if (take_min_d) min_idx_q <= cnt_q;
      if (take_max_d) max_idx_q <= cnt_q;
    end
  end

  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (take_min_d) min_q <= in_data;
      if (take_max_d) max_q <= in_data;
      case (state_q)
        COLLECT: begin
          if (accept_d) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q       <= '0;
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= COLLECT;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_min   = min_q;
  assign out_max   = max_q;

endmodule

`default_nettype wire
